// File: rtl/cp_ex.sv
// cp_ex: execute stage with single-cycle ALU ops and an iterative shift-add multiply.
module cp_ex #(
  parameter int DATA_WIDTH     = 32,
  parameter int RF_INDEX_WIDTH = 5
) (
  input  logic                      iClk,
  input  logic                      iReset,
  input  logic                      iID_EX_Valid,
  input  logic [3:0]                iID_EX_Opcode,
  input  logic [DATA_WIDTH-1:0]     iID_EX_Operand_A,
  input  logic [DATA_WIDTH-1:0]     iID_EX_Operand_B,
  input  logic                      iID_EX_Write_RF_Enable,
  input  logic [RF_INDEX_WIDTH-1:0] iID_EX_Write_RF_Address,
  output logic                      oEX_ID_Stall,
  output logic [DATA_WIDTH-1:0]     oEX_WB_Write_RF_Data,
  output logic [RF_INDEX_WIDTH-1:0] oEX_WB_Write_RF_Address,
  output logic                      oEX_WB_Write_RF_Enable
);
  localparam int SW = $clog2(DATA_WIDTH);
  typedef enum logic {IDLE, MUL} state_t;
  state_t                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d, alu_res, step_sum;
  logic [SW-1:0]             cnt_q, cnt_d, sh;
  logic [RF_INDEX_WIDTH-1:0] addr_q, addr_d, mul_addr_q, mul_addr_d;
  logic                      en_q, en_d, mul_en_q, mul_en_d, alu_op;
  assign sh       = iID_EX_Operand_B[SW-1:0];
  assign alu_op   = iID_EX_Opcode >= 4'd1 && iID_EX_Opcode <= 4'd10;
  assign step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  always_comb begin
    alu_res = '0;
    case (iID_EX_Opcode)
      4'd1:    alu_res = iID_EX_Operand_A + iID_EX_Operand_B;
      4'd2:    alu_res = iID_EX_Operand_A - iID_EX_Operand_B;
      4'd3:    alu_res = iID_EX_Operand_A & iID_EX_Operand_B;
      4'd4:    alu_res = iID_EX_Operand_A | iID_EX_Operand_B;
      4'd5:    alu_res = iID_EX_Operand_A ^ iID_EX_Operand_B;
      4'd6:    alu_res = iID_EX_Operand_A << sh;
      4'd7:    alu_res = iID_EX_Operand_A >> sh;
      4'd8:    alu_res = $signed(iID_EX_Operand_A) >>> sh;
      4'd9:    alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(iID_EX_Operand_A) < $signed(iID_EX_Operand_B)};
      4'd10:   alu_res = {{(DATA_WIDTH-1){1'b0}}, iID_EX_Operand_A < iID_EX_Operand_B};
      default: alu_res = '0;
    endcase
  end
  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    mul_addr_d = mul_addr_q;
    mul_en_d   = mul_en_q;
    data_d     = data_q;
    addr_d     = addr_q;
    en_d       = 1'b0;
    if (state_q == IDLE) begin
      if (iID_EX_Valid && iID_EX_Opcode == 4'd11) begin
        mcand_d    = iID_EX_Operand_A;
        mplier_d   = iID_EX_Operand_B;
        acc_d      = '0;
        mul_addr_d = iID_EX_Write_RF_Address;
        mul_en_d   = iID_EX_Write_RF_Enable;
        cnt_d      = SW'(DATA_WIDTH - 1);
        state_d    = MUL;
      end else if (iID_EX_Valid && alu_op && iID_EX_Write_RF_Enable) begin
        data_d = alu_res;
        addr_d = iID_EX_Write_RF_Address;
        en_d   = 1'b1;
      end
    end else begin
      acc_d    = step_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - 1'b1;
      // Last step: the sum is forwarded straight to WB rather than via acc_q.
      if (cnt_q == '0) begin
        cnt_d   = '0;
        state_d = IDLE;
        if (mul_en_q) begin
          data_d = step_sum;
          addr_d = mul_addr_q;
          en_d   = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      state_q    <= IDLE;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      mul_addr_q <= '0;
      mul_en_q   <= 1'b0;
      data_q     <= '0;
      addr_q     <= '0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      mul_addr_q <= mul_addr_d;
      mul_en_q   <= mul_en_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      en_q       <= en_d;
    end
  end
  assign oEX_ID_Stall            = state_q == MUL;
  assign oEX_WB_Write_RF_Data    = data_q;
  assign oEX_WB_Write_RF_Address = addr_q;
  assign oEX_WB_Write_RF_Enable  = en_q;
endmodule

// File: tb/tb_cp_ex.sv
// tb_cp_ex: directed and random checks of cp_ex against a transaction-level reference model.
module tb_cp_ex;
  localparam int DW = 32, AW = 5;
  logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0, we = 1'b0;
  logic [3:0] op = '0;
  logic [DW-1:0] a = '0, b = '0;
  logic [AW-1:0] addr = '0;
  logic stall, wen;
  logic [DW-1:0] wdata;
  logic [AW-1:0] waddr;
  int checks = 0, failures = 0;
  int busy = 0;
  logic m_en = 1'b0, p_en = 1'b0;
  logic [DW-1:0] m_data = '0, p_data = '0;
  logic [AW-1:0] m_addr = '0, p_addr = '0;
  always #5 clk = ~clk;
  cp_ex #(.DATA_WIDTH(DW), .RF_INDEX_WIDTH(AW)) dut (
    .iClk(clk), .iReset(rst_n), .iID_EX_Valid(valid), .iID_EX_Opcode(op),
    .iID_EX_Operand_A(a), .iID_EX_Operand_B(b), .iID_EX_Write_RF_Enable(we),
    .iID_EX_Write_RF_Address(addr), .oEX_ID_Stall(stall), .oEX_WB_Write_RF_Data(wdata),
    .oEX_WB_Write_RF_Address(waddr), .oEX_WB_Write_RF_Enable(wen)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] ref_op(input logic [3:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y);
    int s;
    logic [63:0] p;
    s = int'(y % DW);
    p = {32'd0, x} * {32'd0, y};
    case (o)
      4'd1: return x + y;
      4'd2: return x - y;
      4'd3: return x & y;
      4'd4: return x | y;
      4'd5: return x ^ y;
      4'd6: return x << s;
      4'd7: return x >> s;
      4'd8: return x[DW-1] ? ~((~x) >> s) : x >> s;
      4'd9: return ($signed(x) < $signed(y)) ? 1 : 0;
      4'd10: return (x < y) ? 1 : 0;
      4'd11: return p[DW-1:0];
      default: return '0;
    endcase
  endfunction
  task automatic model_reset();
    busy = 0; m_en = 0; m_data = '0; m_addr = '0; p_en = 0;
  endtask
  task automatic cycle(input logic v, input logic [3:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y,
                       input logic w, input logic [AW-1:0] d);
    valid = v; op = o; a = x; b = y; we = w; addr = d;
    @(posedge clk);
    if (busy > 0) begin
      busy--;
      m_en = 0;
      if (busy == 0 && p_en) begin m_en = 1; m_data = p_data; m_addr = p_addr; end
    end else if (v && o == 4'd11) begin
      busy = DW; p_data = ref_op(o, x, y); p_addr = d; p_en = w; m_en = 0;
    end else if (v && o >= 4'd1 && o <= 4'd10 && w) begin
      m_en = 1; m_data = ref_op(o, x, y); m_addr = d;
    end else m_en = 0;
    @(negedge clk);
    check("stall", stall, busy > 0);
    check("wen", wen, m_en);
    check("wdata", wdata, m_data);
    check("waddr", waddr, m_addr);
  endtask
  task automatic run_mul(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [AW-1:0] d, input logic [DW-1:0] ex);
    int n;
    n = 0;
    cycle(1, 4'd11, x, y, 1, d);
    while (stall && n < 40) begin
      n++;
      cycle(1, 4'd1, 10, 20, 1, 2);
    end
    check("mul_stall_cycles", n, 32);
    check("mul_data", wdata, ex);
    check("mul_addr", waddr, d);
    check("mul_en", wen, 1);
  endtask
  function automatic logic [DW-1:0] rnd();
    case ($urandom % 6)
      0: return '0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    logic [3:0] o;
    #12;
    check("rst_stall", stall, 0);
    check("rst_wen", wen, 0);
    check("rst_wdata", wdata, 0);
    check("rst_waddr", waddr, 0);
    @(negedge clk) rst_n = 1;
    cycle(1, 4'd1, 32'h7FFF_FFFF, 1, 1, 3);
    check("add_ovf", wdata, 32'h8000_0000);
    check("add_addr", waddr, 3);
    cycle(1, 4'd2, 0, 1, 1, 4);
    check("sub", wdata, 32'hFFFF_FFFF);
    cycle(1, 4'd8, 32'h8000_0000, 4, 1, 5);
    check("sra", wdata, 32'hF800_0000);
    cycle(1, 4'd6, 1, 33, 1, 6);
    check("sll_mask", wdata, 2);
    cycle(1, 4'd7, 32'h8000_0000, 31, 1, 6);
    check("srl", wdata, 1);
    cycle(1, 4'd9, 32'hFFFF_FFFF, 1, 1, 8);
    check("slt", wdata, 1);
    cycle(1, 4'd10, 32'hFFFF_FFFF, 1, 1, 9);
    check("sltu", wdata, 0);
    cycle(1, 4'd13, 5, 5, 1, 10);
    check("rsvd_en", wen, 0);
    check("rsvd_addr", waddr, 9);
    run_mul(32'h0000_FFFF, 32'h0001_0001, 7, 32'hFFFF_FFFF);
    cycle(1, 4'd1, 10, 20, 1, 2);
    check("held_add", wdata, 30);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 11, 1);
    run_mul(32'h1234_5678, 0, 12, 0);
    cycle(1, 4'd11, 3, 5, 1, 12);
    repeat (9) cycle(0, 4'd0, 0, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    check("arst_stall", stall, 0);
    check("arst_wen", wen, 0);
    check("arst_wdata", wdata, 0);
    check("arst_waddr", waddr, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk) rst_n = 1;
    cycle(1, 4'd1, 2, 3, 1, 13);
    check("post_rst_add", wdata, 5);
    check("post_rst_en", wen, 1);
    repeat (40) cycle(0, 4'd0, 0, 0, 0, 0);
    repeat (2000) begin
      o = 4'($urandom % 16);
      if (o == 4'd11 && ($urandom % 3) != 0) o = 4'd1;
      cycle(($urandom % 4) != 0, o, rnd(), rnd(), ($urandom % 5) != 0, AW'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
